// File: rtl/trigger_gen.sv
// Threshold trigger for a multi-lane ADC stream: raises a fixed-length
// acquisition window on the first over-threshold beat, then holds off.
module trigger_gen #(
    parameter int THRESHOLD            = 10,
    parameter int PRE_ACQUI_LEN        = 12,
    parameter int POST_ACQUI_LEN       = 38,
    parameter int HOLDOFF_LEN          = 4,
    parameter int TIME_STAMP_WIDTH     = 16,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int S_AXIS_TDATA_WIDTH   = 128
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESET,
    input  logic                          ENABLE,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    input  logic                          S_AXIS_TREADY,
    input  logic                          FIFO_FULL,
    output logic                          TRIGGERD_FLAG,
    output logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
    output logic [31:0]                   TRIG_CNT,
    output logic [15:0]                   DROP_CNT
);

    localparam int LANES         = S_AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
    localparam int ADW           = ADC_RESOLUTION_WIDTH;
    localparam int THRESHOLD_VAL = (THRESHOLD * 2048) / 100;
    localparam int WIN_LEN       = PRE_ACQUI_LEN + POST_ACQUI_LEN;
    localparam int WW            = $clog2(WIN_LEN + 1);
    localparam int HW            = $clog2(HOLDOFF_LEN + 2);

    localparam logic signed [ADW:0] THR_VAL  = (ADW + 1)'(THRESHOLD_VAL);
    localparam logic [WW-1:0]       WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [HW-1:0]       HO_LAST  = HW'(HOLDOFF_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_HOLDOFF
    } state_e;

    state_e                      state_q, state_d;
    logic [TIME_STAMP_WIDTH-1:0] ts_cnt_q;
    logic [TIME_STAMP_WIDTH-1:0] ts_r_q;
    logic                        hit_q, hit_d;
    logic [WW-1:0]               win_q, win_d;
    logic [HW-1:0]               ho_q, ho_d;
    logic [TIME_STAMP_WIDTH-1:0] tstamp_q, tstamp_d;
    logic [31:0]                 trig_q, trig_d;
    logic [15:0]                 drop_q, drop_d;
    logic signed [ADW:0]         smp;

    // One extra sign bit so a 100% threshold (2048) still compares correctly.
    always_comb begin
        hit_d = 1'b0;
        smp   = '0;
        for (int l = 0; l < LANES; l++) begin
            smp = {S_AXIS_TDATA[l*SAMPLE_WIDTH + SAMPLE_WIDTH - 1],
                   S_AXIS_TDATA[l*SAMPLE_WIDTH + SAMPLE_WIDTH - 1 -: ADW]};
            if (smp > THR_VAL) begin
                hit_d = 1'b1;
            end
        end
        hit_d = hit_d & S_AXIS_TVALID & S_AXIS_TREADY;
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ho_d     = ho_q;
        tstamp_d = tstamp_q;
        trig_d   = trig_q;
        drop_d   = drop_q;
        unique case (state_q)
            S_IDLE: begin
                if (hit_q && ENABLE) begin
                    if (!FIFO_FULL) begin
                        state_d  = S_ACQ;
                        tstamp_d = ts_r_q;
                        trig_d   = trig_q + 32'd1;
                        win_d    = '0;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            S_ACQ: begin
                if (win_q == WIN_LAST) begin
                    ho_d    = '0;
                    state_d = (HOLDOFF_LEN == 0) ? S_IDLE : S_HOLDOFF;
                end else begin
                    win_d = win_q + WW'(1);
                end
            end
            S_HOLDOFF: begin
                if (ho_q == HO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ho_d = ho_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q  <= S_IDLE;
            ts_cnt_q <= '0;
            ts_r_q   <= '0;
            hit_q    <= 1'b0;
            win_q    <= '0;
            ho_q     <= '0;
            tstamp_q <= '0;
            trig_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            ts_cnt_q <= ts_cnt_q + TIME_STAMP_WIDTH'(1);
            ts_r_q   <= ts_cnt_q;
            hit_q    <= hit_d;
            win_q    <= win_d;
            ho_q     <= ho_d;
            tstamp_q <= tstamp_d;
            trig_q   <= trig_d;
            drop_q   <= drop_d;
        end
    end

    assign TRIGGERD_FLAG = (state_q == S_ACQ);
    assign TIME_STAMP    = tstamp_q;
    assign TRIG_CNT      = trig_q;
    assign DROP_CNT      = drop_q;

endmodule

// File: tb/tb_trigger_gen.sv
// Directed bench for trigger_gen: threshold edge, sign, handshake,
// back-to-back windows, FIFO veto, mid-window reset, time stamp wrap.
module tb_trigger_gen;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         full;
    logic         flag;
    logic [15:0]  tstamp;
    logic [31:0]  trig_cnt;
    logic [15:0]  drop_cnt;

    logic [15:0]  ts_m;
    int           n_tests;
    int           n_fail;

    trigger_gen dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .ENABLE        (en),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .FIFO_FULL     (full),
        .TRIGGERD_FLAG (flag),
        .TIME_STAMP    (tstamp),
        .TRIG_CNT      (trig_cnt),
        .DROP_CNT      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference free-running time stamp
    always @(posedge clk) ts_m <= rst ? 16'd0 : ts_m + 16'd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic no_trig(input string tag, input logic [127:0] d,
                           input logic rdy);
        logic seen;
        logic [31:0] tc;
        seen = 1'b0;
        tc = trig_cnt;
        tdata = d;
        tvalid = 1'b1;
        tready = rdy;
        tick();
        tdata = '0;
        tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            seen |= flag;
            tick();
        end
        chk({tag, "_flag"}, 32'(seen), 32'd0);
        chk({tag, "_cnt"}, trig_cnt, tc);
    endtask

    initial begin
        int cnt;
        logic seen;
        logic [15:0] ts_prev;
        logic [31:0] tc_prev;
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        en = 1'b1;
        tvalid = 1'b1;
        tready = 1'b1;
        full = 1'b0;
        tdata = {$urandom, $urandom, $urandom, $urandom};

        // Reset held three edges with noisy data
        for (int i = 0; i < 3; i++) begin
            tdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_ts", 32'(tstamp), 32'd0);
        chk("rst_trig", trig_cnt, 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_tscnt", 32'(dut.ts_cnt_q), 32'd0);
        tdata = '0;
        tvalid = 1'b0;
        rst = 1'b0;
        tick();

        // Exactly at threshold (204) must not fire
        seen = 1'b0;
        tdata = 128'h0CC0 << 48;
        tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= flag;
        end
        tdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= flag;
        end
        chk("thr204_noflag", 32'(seen), 32'd0);

        // 205 at ts=100
        cnt = 0;
        while (ts_m != 16'd100 && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("wait_ts100", 32'(ts_m), 32'd100);
        tdata = 128'h0CD0 << 48;
        tick();
        tdata = '0;
        chk("lat_c1_low", 32'(flag), 32'd0);
        tick();
        chk("lat_c2_high", 32'(flag), 32'd1);
        chk("win1_ts", 32'(tstamp), 32'd100);
        chk("win1_trig", trig_cnt, 32'd1);
        cnt = 0;
        while (flag && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("win1_len", 32'(cnt), 32'd50);
        for (int i = 0; i < 6; i++) tick();

        // Sign and handshake
        no_trig("neg_full", 128'h8000, 1'b1);
        no_trig("no_ready", 128'h7FF0, 1'b0);

        // Continuous hits
        tdata = 128'h7FF0 << 48;
        tvalid = 1'b1;
        cnt = 0;
        while (!flag && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("cont_rise", 32'(cnt), 32'd2);
        chk("cont_ts0", 32'(tstamp), 32'(16'(ts_m - 16'd2)));
        chk("cont_trig0", trig_cnt, 32'd2);
        for (int w = 0; w < 3; w++) begin
            ts_prev = tstamp;
            tc_prev = trig_cnt;
            cnt = 0;
            while (flag && cnt < 100) begin
                cnt++;
                tick();
            end
            chk("cont_high", 32'(cnt), 32'd50);
            cnt = 0;
            while (!flag && cnt < 100) begin
                cnt++;
                tick();
            end
            chk("cont_low", 32'(cnt), 32'd5);
            chk("cont_ts_step", 32'(tstamp), 32'(16'(ts_prev + 16'd55)));
            chk("cont_trig_step", trig_cnt, tc_prev + 32'd1);
        end
        tvalid = 1'b0;
        tdata = '0;
        cnt = 0;
        while (flag && cnt < 100) begin
            cnt++;
            tick();
        end
        for (int i = 0; i < 6; i++) tick();

        // FIFO full veto
        tc_prev = trig_cnt;
        full = 1'b1;
        seen = 1'b0;
        tdata = 128'h7FF0;
        tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= flag;
        end
        tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            seen |= flag;
        end
        chk("full_noflag", 32'(seen), 32'd0);
        chk("full_drop", 32'(drop_cnt), 32'd10);
        chk("full_trig", trig_cnt, tc_prev);
        full = 1'b0;
        tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        tick();
        chk("rel_flag", 32'(flag), 32'd1);
        chk("rel_trig", trig_cnt, tc_prev + 32'd1);

        // Reset at win_cnt=20
        for (int i = 0; i < 20; i++) tick();
        chk("mid_win", 32'(dut.win_q), 32'd20);
        rst = 1'b1;
        tick();
        chk("mid_rst_flag", 32'(flag), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'd0);
        chk("mid_rst_trig", trig_cnt, 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // Trigger at ts_cnt=0xFFFF
        cnt = 0;
        while (ts_m != 16'hFFFF && cnt < 70000) begin
            tick();
            cnt++;
        end
        chk("wait_ffff", 32'(ts_m), 32'hFFFF);
        tdata = 128'h0CD0 << 112;
        tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        chk("wrap_cnt", 32'(dut.ts_cnt_q), 32'd0);
        tick();
        chk("wrap_flag", 32'(flag), 32'd1);
        chk("wrap_ts", 32'(tstamp), 32'hFFFF);
        chk("wrap_trig", trig_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
